// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the 5-stage LoongArch pipeline.
// Commits one instruction per handshake: GPR write, CSR access, TLB-op strobe,
// exception / ertn / refetch commit and the resulting pipeline flush.
// TLB ops take two cycles: the strobe cycle (StRun) and the commit cycle (StTlbWait).
// Optional feature: define WB_TRACE_EN to drive the debug_wb_* trace outputs;
// otherwise they are tied off (debug_wb_pc holds PC_RESET).

module wb_stage #(
    parameter logic [31:0] PC_RESET = 32'h1bfffffc,
    parameter int unsigned EXC_W    = 15
) (
    input  logic             clk,
    input  logic             reset,

    // Handshake with the memory stage
    input  logic             mem_to_wb_valid,
    output logic             wb_allowin,

    // Instruction payload from the memory stage
    input  logic [31:0]      pc_i,
    input  logic             gr_we_i,
    input  logic [4:0]       dest_i,
    input  logic [31:0]      final_result_i,
    input  logic [1:0]       csr_inst_type_i,
    input  logic [13:0]      csr_num_i,
    input  logic [31:0]      rkd_value_i,
    input  logic [31:0]      rj_value_i,
    input  logic             inst_ertn_i,
    input  logic [2:0]       op_tlb_i,
    input  logic [EXC_W-1:0] exc_vec_i,
    input  logic [31:0]      vaddr_i,

    // CSR file access
    input  logic [31:0]      csr_rdata,
    output logic             csr_we,
    output logic [13:0]      csr_num,
    output logic [31:0]      csr_wdata,
    output logic [31:0]      csr_wmask,

    // TLB op strobe
    output logic [2:0]       tlb_op,

    // Commit / flush
    output logic             flush,
    output logic             exc_commit,
    output logic [5:0]       ecode,
    output logic [8:0]       esubcode,
    output logic [31:0]      exc_pc,
    output logic             badv_we,
    output logic [31:0]      badv,
    output logic             ertn_commit,
    output logic             refetch_commit,
    output logic [31:0]      refetch_pc,

    // Register file write
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,

    // Forwarding to decode
    output logic             wb_fwd_valid,
    output logic [4:0]       wb_fwd_dest,

    // Trace
    output logic [31:0]      debug_wb_pc,
    output logic [3:0]       debug_wb_rf_we,
    output logic [4:0]       debug_wb_rf_wnum,
    output logic [31:0]      debug_wb_rf_wdata
);

    typedef enum logic [0:0] {
        StRun,
        StTlbWait
    } state_e;

    state_e state_q, state_d;

    // Captured instruction
    logic             wb_valid_q;
    logic [31:0]      pc_q;
    logic             gr_we_q;
    logic [4:0]       dest_q;
    logic [31:0]      final_result_q;
    logic [1:0]       csr_inst_type_q;
    logic [13:0]      csr_num_q;
    logic [31:0]      rkd_value_q;
    logic [31:0]      rj_value_q;
    logic             inst_ertn_q;
    logic [2:0]       op_tlb_q;
    logic [EXC_W-1:0] exc_vec_q;
    logic [31:0]      vaddr_q;

    // Internal control
    logic       wb_readygo;
    logic       wb_accept;
    logic       is_tlb;
    logic       exc;
    logic       tlb_issue;
    logic       commit_cycle;
    logic       commit_ok;
    logic [3:0] exc_idx;
    logic       cause_fetch_side;
    logic       cause_has_badv;
    logic [5:0] ecode_raw;

    assign is_tlb     = (op_tlb_q != 3'b000);
    assign exc        = wb_valid_q & (|exc_vec_q[13:0]);
    assign wb_allowin = ~wb_valid_q | wb_readygo;
    // A flush in the same cycle discards whatever the memory stage offers
    assign wb_accept  = mem_to_wb_valid & wb_allowin & ~flush;

    // Valid bit: flush has priority over capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
        end else if (flush) begin
            wb_valid_q <= 1'b0;
        end else if (wb_allowin) begin
            wb_valid_q <= mem_to_wb_valid;
        end
    end

    // Payload registers, loaded only on an accepted handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q            <= PC_RESET;
            gr_we_q         <= 1'b0;
            dest_q          <= 5'd0;
            final_result_q  <= 32'd0;
            csr_inst_type_q <= 2'b00;
            csr_num_q       <= 14'd0;
            rkd_value_q     <= 32'd0;
            rj_value_q      <= 32'd0;
            inst_ertn_q     <= 1'b0;
            op_tlb_q        <= 3'b000;
            exc_vec_q       <= '0;
            vaddr_q         <= 32'd0;
        end else if (wb_accept) begin
            pc_q            <= pc_i;
            gr_we_q         <= gr_we_i;
            dest_q          <= dest_i;
            final_result_q  <= final_result_i;
            csr_inst_type_q <= csr_inst_type_i;
            csr_num_q       <= csr_num_i;
            rkd_value_q     <= rkd_value_i;
            rj_value_q      <= rj_value_i;
            inst_ertn_q     <= inst_ertn_i;
            op_tlb_q        <= op_tlb_i;
            exc_vec_q       <= exc_vec_i;
            vaddr_q         <= vaddr_i;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a TLB op without exception spends one cycle in StTlbWait
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:     if (tlb_issue) state_d = StTlbWait;
            StTlbWait: state_d = StRun;
            default:   state_d = StRun;
        endcase
    end

    // FSM outputs: stall and strobe in StRun for TLB ops, commit otherwise
    always_comb begin
        wb_readygo   = 1'b1;
        tlb_issue    = 1'b0;
        commit_cycle = 1'b0;
        unique case (state_q)
            StRun: begin
                if (wb_valid_q && is_tlb && !exc) begin
                    wb_readygo = 1'b0;
                    tlb_issue  = 1'b1;
                end else begin
                    commit_cycle = wb_valid_q & ~is_tlb;
                end
            end
            StTlbWait: begin
                commit_cycle = wb_valid_q;
            end
            default: begin
                wb_readygo = 1'b1;
            end
        endcase
    end

    assign commit_ok = commit_cycle & ~exc;

    // Exception priority encoder: lowest set index wins
    always_comb begin
        exc_idx = 4'd0;
        for (int i = 13; i >= 0; i--) begin
            if (exc_vec_q[i]) exc_idx = i[3:0];
        end
    end

    // Cause index to ecode
    always_comb begin
        ecode_raw = 6'h00;
        case (exc_idx)
            4'd0:    ecode_raw = 6'h00; // int
            4'd1:    ecode_raw = 6'h08; // adef
            4'd2:    ecode_raw = 6'h3F; // tlbr (fetch)
            4'd3:    ecode_raw = 6'h03; // pif
            4'd4:    ecode_raw = 6'h07; // ppi (fetch)
            4'd5:    ecode_raw = 6'h0D; // ine
            4'd6:    ecode_raw = 6'h0B; // sys
            4'd7:    ecode_raw = 6'h0C; // brk
            4'd8:    ecode_raw = 6'h09; // ale
            4'd9:    ecode_raw = 6'h3F; // tlbr (mem)
            4'd10:   ecode_raw = 6'h01; // pil
            4'd11:   ecode_raw = 6'h02; // pis
            4'd12:   ecode_raw = 6'h04; // pme
            4'd13:   ecode_raw = 6'h07; // ppi (mem)
            default: ecode_raw = 6'h00;
        endcase
    end

    // BADV is decided by the winning cause only, not by lower-priority flags
    assign cause_fetch_side = (exc_idx >= 4'd1) && (exc_idx <= 4'd4);
    assign cause_has_badv   = cause_fetch_side || (exc_idx >= 4'd8);

    assign exc_commit = exc;
    assign ecode      = exc ? ecode_raw : 6'h00;
    assign esubcode   = 9'd0;
    assign exc_pc     = pc_q;
    assign badv_we    = exc & cause_has_badv;
    assign badv       = cause_fetch_side ? pc_q : vaddr_q;

    assign ertn_commit    = commit_ok & inst_ertn_q;
    assign refetch_commit = commit_ok & (exc_vec_q[14] | is_tlb);
    assign refetch_pc     = pc_q + 32'd4;
    assign flush          = exc | ertn_commit | refetch_commit;

    assign tlb_op = tlb_issue ? op_tlb_q : 3'b000;

    // CSR access; csr_num is live whenever an instruction sits in WB
    assign csr_num   = csr_num_q;
    assign csr_we    = commit_ok & csr_inst_type_q[0];
    assign csr_wdata = rkd_value_q;
    assign csr_wmask = (csr_inst_type_q == 2'b11) ? rj_value_q : 32'hFFFF_FFFF;

    // Register file write
    assign rf_we    = commit_ok & gr_we_q;
    assign rf_waddr = dest_q;
    assign rf_wdata = (csr_inst_type_q != 2'b00) ? csr_rdata : final_result_q;

    // Forwarding hint to decode
    assign wb_fwd_valid = wb_valid_q & gr_we_q & (dest_q != 5'd0);
    assign wb_fwd_dest  = dest_q;

`ifdef WB_TRACE_EN
    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = dest_q;
    assign debug_wb_rf_wdata = rf_wdata;
`else
    assign debug_wb_pc       = PC_RESET;
    assign debug_wb_rf_we    = 4'b0000;
    assign debug_wb_rf_wnum  = 5'd0;
    assign debug_wb_rf_wdata = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected commit records,
// a negedge monitor pops and compares whenever the DUT shows commit activity.

module tb_wb_stage;

    localparam logic [31:0] PcReset = 32'h1bfffffc;

    logic        clk;
    logic        reset;
    logic        mem_to_wb_valid;
    logic        wb_allowin;
    logic [31:0] pc_i;
    logic        gr_we_i;
    logic [4:0]  dest_i;
    logic [31:0] final_result_i;
    logic [1:0]  csr_inst_type_i;
    logic [13:0] csr_num_i;
    logic [31:0] rkd_value_i;
    logic [31:0] rj_value_i;
    logic        inst_ertn_i;
    logic [2:0]  op_tlb_i;
    logic [14:0] exc_vec_i;
    logic [31:0] vaddr_i;
    logic [31:0] csr_rdata;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wdata;
    logic [31:0] csr_wmask;
    logic [2:0]  tlb_op;
    logic        flush;
    logic        exc_commit;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] exc_pc;
    logic        badv_we;
    logic [31:0] badv;
    logic        ertn_commit;
    logic        refetch_commit;
    logic [31:0] refetch_pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_fwd_valid;
    logic [4:0]  wb_fwd_dest;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    wb_stage #(.PC_RESET(PcReset), .EXC_W(15)) dut (
        .clk(clk), .reset(reset),
        .mem_to_wb_valid(mem_to_wb_valid), .wb_allowin(wb_allowin),
        .pc_i(pc_i), .gr_we_i(gr_we_i), .dest_i(dest_i), .final_result_i(final_result_i),
        .csr_inst_type_i(csr_inst_type_i), .csr_num_i(csr_num_i),
        .rkd_value_i(rkd_value_i), .rj_value_i(rj_value_i), .inst_ertn_i(inst_ertn_i),
        .op_tlb_i(op_tlb_i), .exc_vec_i(exc_vec_i), .vaddr_i(vaddr_i),
        .csr_rdata(csr_rdata), .csr_we(csr_we), .csr_num(csr_num),
        .csr_wdata(csr_wdata), .csr_wmask(csr_wmask), .tlb_op(tlb_op),
        .flush(flush), .exc_commit(exc_commit), .ecode(ecode), .esubcode(esubcode),
        .exc_pc(exc_pc), .badv_we(badv_we), .badv(badv),
        .ertn_commit(ertn_commit), .refetch_commit(refetch_commit), .refetch_pc(refetch_pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_dest(wb_fwd_dest),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    // CSR file stand-in: CSR 0 reads 0xAA, every other CSR reads its own number
    assign csr_rdata = (csr_num == 14'h0) ? 32'h0000_00AA : {18'h0, csr_num};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] res;
        logic [1:0]  csr_type;
        logic [13:0] csr_n;
        logic [31:0] rkd;
        logic [31:0] rj;
        logic        ertn;
        logic [2:0]  op;
        logic [14:0] ev;
        logic [31:0] va;
    } in_t;

    typedef struct {
        int          id;
        logic        allowin;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        csr_we;
        logic [31:0] cwdata;
        logic [31:0] cwmask;
        logic [2:0]  tlb;
        logic        flush;
        logic        exc;
        logic [5:0]  ecode;
        logic        badv_we;
        logic [31:0] badv;
        logic        ertn;
        logic        refetch;
        logic [31:0] refetch_pc;
        logic [31:0] exc_pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    function automatic void chk(input int id, input string name,
                                input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL #%0d %s: got %h, required %h", id, name, act, req);
        end
    endfunction

    function automatic in_t in_blank(input logic [31:0] pc);
        in_t r;
        r.pc = pc; r.gr_we = 1'b0; r.dest = 5'd0; r.res = 32'd0;
        r.csr_type = 2'b00; r.csr_n = 14'd0; r.rkd = 32'd0; r.rj = 32'd0;
        r.ertn = 1'b0; r.op = 3'b000; r.ev = 15'd0; r.va = 32'd0;
        return r;
    endfunction

    function automatic exp_t exp_blank(input int id);
        exp_t e;
        e.id = id; e.allowin = 1'b1; e.rf_we = 1'b0; e.waddr = 5'd0; e.wdata = 32'd0;
        e.csr_we = 1'b0; e.cwdata = 32'd0; e.cwmask = 32'd0; e.tlb = 3'b000;
        e.flush = 1'b0; e.exc = 1'b0; e.ecode = 6'd0; e.badv_we = 1'b0; e.badv = 32'd0;
        e.ertn = 1'b0; e.refetch = 1'b0; e.refetch_pc = 32'd0; e.exc_pc = 32'd0;
        return e;
    endfunction

    task automatic drive_idle();
        mem_to_wb_valid = 1'b0;
        pc_i = 32'd0; gr_we_i = 1'b0; dest_i = 5'd0; final_result_i = 32'd0;
        csr_inst_type_i = 2'b00; csr_num_i = 14'd0; rkd_value_i = 32'd0; rj_value_i = 32'd0;
        inst_ertn_i = 1'b0; op_tlb_i = 3'b000; exc_vec_i = 15'd0; vaddr_i = 32'd0;
    endtask

    // Present one instruction for one cycle; caller sits at posedge+1
    task automatic issue(input in_t i);
        mem_to_wb_valid = 1'b1;
        pc_i = i.pc; gr_we_i = i.gr_we; dest_i = i.dest; final_result_i = i.res;
        csr_inst_type_i = i.csr_type; csr_num_i = i.csr_n; rkd_value_i = i.rkd;
        rj_value_i = i.rj; inst_ertn_i = i.ertn; op_tlb_i = i.op; exc_vec_i = i.ev;
        vaddr_i = i.va;
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: any commit activity must match the head of the scoreboard
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (rf_we || csr_we || flush || exc_commit || ertn_commit ||
                           refetch_commit || tlb_op != 3'b000)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_event: got rf_we=%b flush=%b tlb_op=%h, required none",
                             rf_we, flush, tlb_op);
                end else begin
                    e = exp_q.pop_front();
                    chk(e.id, "wb_allowin", 32'(wb_allowin), 32'(e.allowin));
                    chk(e.id, "rf_we", 32'(rf_we), 32'(e.rf_we));
                    if (e.rf_we) begin
                        chk(e.id, "rf_waddr", 32'(rf_waddr), 32'(e.waddr));
                        chk(e.id, "rf_wdata", rf_wdata, e.wdata);
                    end
                    chk(e.id, "csr_we", 32'(csr_we), 32'(e.csr_we));
                    if (e.csr_we) begin
                        chk(e.id, "csr_wdata", csr_wdata, e.cwdata);
                        chk(e.id, "csr_wmask", csr_wmask, e.cwmask);
                    end
                    chk(e.id, "tlb_op", 32'(tlb_op), 32'(e.tlb));
                    chk(e.id, "flush", 32'(flush), 32'(e.flush));
                    chk(e.id, "exc_commit", 32'(exc_commit), 32'(e.exc));
                    chk(e.id, "ecode", 32'(ecode), 32'(e.ecode));
                    chk(e.id, "esubcode", 32'(esubcode), 32'd0);
                    chk(e.id, "badv_we", 32'(badv_we), 32'(e.badv_we));
                    if (e.badv_we) chk(e.id, "badv", badv, e.badv);
                    if (e.exc) chk(e.id, "exc_pc", exc_pc, e.exc_pc);
                    chk(e.id, "ertn_commit", 32'(ertn_commit), 32'(e.ertn));
                    chk(e.id, "refetch_commit", 32'(refetch_commit), 32'(e.refetch));
                    if (e.refetch) chk(e.id, "refetch_pc", refetch_pc, e.refetch_pc);
`ifdef WB_TRACE_EN
                    chk(e.id, "debug_wb_rf_we", 32'(debug_wb_rf_we), 32'({4{e.rf_we}}));
`else
                    chk(e.id, "debug_wb_rf_we", 32'(debug_wb_rf_we), 32'd0);
`endif
                end
            end
        end
    end

    task automatic check_quiet(input int id);
        chk(id, "rst_wb_allowin", 32'(wb_allowin), 32'd1);
        chk(id, "rst_rf_we", 32'(rf_we), 32'd0);
        chk(id, "rst_csr_we", 32'(csr_we), 32'd0);
        chk(id, "rst_tlb_op", 32'(tlb_op), 32'd0);
        chk(id, "rst_flush", 32'(flush), 32'd0);
        chk(id, "rst_exc_commit", 32'(exc_commit), 32'd0);
        chk(id, "rst_refetch", 32'(refetch_commit), 32'd0);
        chk(id, "rst_ertn", 32'(ertn_commit), 32'd0);
        chk(id, "rst_fwd_valid", 32'(wb_fwd_valid), 32'd0);
        chk(id, "rst_debug_wb_pc", debug_wb_pc, PcReset);
        chk(id, "rst_debug_wb_rf_we", 32'(debug_wb_rf_we), 32'd0);
    endtask

    initial begin : stim
        in_t  i;
        exp_t e;
        drive_idle();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_quiet(0);
        chk(0, "rst_refetch_pc", refetch_pc, 32'h1c000000);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(1);

        // ALU commits, back to back
        i = in_blank(32'h1c000000); i.gr_we = 1'b1; i.dest = 5'd5; i.res = 32'h1234;
        e = exp_blank(1); e.rf_we = 1'b1; e.waddr = 5'd5; e.wdata = 32'h1234;
        exp_q.push_back(e); issue(i);
        i = in_blank(32'h1c000004); i.gr_we = 1'b1; i.dest = 5'd6; i.res = 32'h5678;
        e = exp_blank(2); e.rf_we = 1'b1; e.waddr = 5'd6; e.wdata = 32'h5678;
        exp_q.push_back(e); issue(i);
        idle(1);

        // csrxchg on CSR 0
        i = in_blank(32'h1c000008); i.gr_we = 1'b1; i.dest = 5'd7; i.res = 32'hDEAD;
        i.csr_type = 2'b11; i.csr_n = 14'h0; i.rkd = 32'hF0; i.rj = 32'h0F;
        e = exp_blank(3); e.rf_we = 1'b1; e.waddr = 5'd7; e.wdata = 32'hAA;
        e.csr_we = 1'b1; e.cwdata = 32'hF0; e.cwmask = 32'h0F;
        exp_q.push_back(e); issue(i);
        // csrwr on CSR 5: full mask, old value to GPR
        i = in_blank(32'h1c00000c); i.gr_we = 1'b1; i.dest = 5'd8;
        i.csr_type = 2'b01; i.csr_n = 14'h5; i.rkd = 32'h12345678; i.rj = 32'h0F;
        e = exp_blank(4); e.rf_we = 1'b1; e.waddr = 5'd8; e.wdata = 32'h5;
        e.csr_we = 1'b1; e.cwdata = 32'h12345678; e.cwmask = 32'hFFFFFFFF;
        exp_q.push_back(e); issue(i);
        // csrrd on CSR 7: no CSR write
        i = in_blank(32'h1c00000e); i.gr_we = 1'b1; i.dest = 5'd9;
        i.csr_type = 2'b10; i.csr_n = 14'h7; i.res = 32'h1111;
        e = exp_blank(5); e.rf_we = 1'b1; e.waddr = 5'd9; e.wdata = 32'h7;
        exp_q.push_back(e); issue(i);
        idle(1);

        // ine + ale: ine wins, no BADV
        i = in_blank(32'h1c000010); i.gr_we = 1'b1; i.dest = 5'd10;
        i.ev = 15'h0120; i.va = 32'h1003;
        e = exp_blank(6); e.flush = 1'b1; e.exc = 1'b1; e.ecode = 6'h0D;
        e.exc_pc = 32'h1c000010;
        exp_q.push_back(e); issue(i);
        idle(1);
        // ale alone
        i = in_blank(32'h1c000014); i.gr_we = 1'b1; i.dest = 5'd10;
        i.ev = 15'h0100; i.va = 32'h1003;
        e = exp_blank(7); e.flush = 1'b1; e.exc = 1'b1; e.ecode = 6'h09;
        e.badv_we = 1'b1; e.badv = 32'h1003; e.exc_pc = 32'h1c000014;
        exp_q.push_back(e); issue(i);
        idle(1);
        // adef + ale: adef wins, BADV is the PC
        i = in_blank(32'h1c000021); i.ev = 15'h0102; i.va = 32'h1003;
        e = exp_blank(8); e.flush = 1'b1; e.exc = 1'b1; e.ecode = 6'h08;
        e.badv_we = 1'b1; e.badv = 32'h1c000021; e.exc_pc = 32'h1c000021;
        exp_q.push_back(e); issue(i);
        idle(1);
        // pil + pme: pil wins
        i = in_blank(32'h1c000024); i.ev = 15'h1400; i.va = 32'h2000;
        e = exp_blank(9); e.flush = 1'b1; e.exc = 1'b1; e.ecode = 6'h01;
        e.badv_we = 1'b1; e.badv = 32'h2000; e.exc_pc = 32'h1c000024;
        exp_q.push_back(e); issue(i);
        idle(1);

        // tlbrd: strobe cycle with stall, then refetch commit
        i = in_blank(32'h1c000030); i.op = 3'b011;
        e = exp_blank(10); e.tlb = 3'b011; e.allowin = 1'b0;
        exp_q.push_back(e);
        e = exp_blank(11); e.flush = 1'b1; e.refetch = 1'b1; e.refetch_pc = 32'h1c000034;
        exp_q.push_back(e); issue(i);
        idle(2);

        // ertn with an instruction arriving in the same cycle: that one is dropped
        i = in_blank(32'h1c000040); i.ertn = 1'b1;
        e = exp_blank(12); e.ertn = 1'b1; e.flush = 1'b1;
        exp_q.push_back(e); issue(i);
        i = in_blank(32'h1c000044); i.gr_we = 1'b1; i.dest = 5'd9; i.res = 32'hBAD;
        issue(i);
        idle(2);

        // refetch flag: GPR still written, then restart at pc+4
        i = in_blank(32'h1c000050); i.gr_we = 1'b1; i.dest = 5'd3; i.res = 32'h77;
        i.ev = 15'h4000;
        e = exp_blank(13); e.rf_we = 1'b1; e.waddr = 5'd3; e.wdata = 32'h77;
        e.flush = 1'b1; e.refetch = 1'b1; e.refetch_pc = 32'h1c000054;
        exp_q.push_back(e); issue(i);
        idle(1);

        // interrupt on a TLB op: exception, no strobe, no TLB_WAIT
        i = in_blank(32'h1c000060); i.op = 3'b010; i.ev = 15'h0001;
        e = exp_blank(14); e.flush = 1'b1; e.exc = 1'b1; e.ecode = 6'h00;
        e.exc_pc = 32'h1c000060;
        exp_q.push_back(e); issue(i);
        idle(2);

        // tlbsrch, then reset while in TLB_WAIT
        i = in_blank(32'h1c000070); i.op = 3'b001;
        e = exp_blank(15); e.tlb = 3'b001; e.allowin = 1'b0;
        exp_q.push_back(e); issue(i);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_quiet(16);
        @(posedge clk);
        #1 reset = 1'b0;
        // Back in RUN: an ALU op commits in its first WB cycle
        i = in_blank(32'h1c000080); i.gr_we = 1'b1; i.dest = 5'd4; i.res = 32'h4444;
        e = exp_blank(17); e.rf_we = 1'b1; e.waddr = 5'd4; e.wdata = 32'h4444;
        exp_q.push_back(e); issue(i);
        idle(3);

        chk(99, "scoreboard_left", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
